// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline-register slice:
//   - control_t / pipeline_signal_t : packed image carried between stages
//   - pipeline_signal_width()       : payload width of pipeline_signal_t
//   - CONTROL_MASK                  : every bit of the control field
//   - COP0_KEEP_MASK                : write_cop0 and dest_cop0_rd/sel/data
//   - INSTR_FIELD_MASK              : the instruction word
//   - CLEAR_PIPELINE_SIGNAL         : packed clear image (get_clear_control)
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef struct packed {
        logic [14:0] spare;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest_reg;
        logic        write_cop0;
        logic [4:0]  dest_cop0_rd;
        logic [2:0]  dest_cop0_sel;
        logic [31:0] dest_cop0_data;
    } control_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        control_t    ctrl;
    } pipeline_signal_t;

    function automatic int pipeline_signal_width();
        return $bits(pipeline_signal_t);
    endfunction

    localparam int PIPELINE_SIGNAL_W = $bits(pipeline_signal_t);

    // Clear image: an idle stage carries no writes and no memory access.
    function automatic pipeline_signal_t get_clear_control();
        pipeline_signal_t s;
        s = '0;
        return s;
    endfunction

    function automatic pipeline_signal_t control_mask_f();
        pipeline_signal_t m;
        m = '0;
        m.ctrl = '1;
        return m;
    endfunction

    function automatic pipeline_signal_t cop0_keep_mask_f();
        pipeline_signal_t m;
        m = '0;
        m.ctrl.write_cop0     = 1'b1;
        m.ctrl.dest_cop0_rd   = '1;
        m.ctrl.dest_cop0_sel  = '1;
        m.ctrl.dest_cop0_data = '1;
        return m;
    endfunction

    function automatic pipeline_signal_t instr_mask_f();
        pipeline_signal_t m;
        m = '0;
        m.instr = '1;
        return m;
    endfunction

    localparam pipeline_signal_t CONTROL_MASK          = control_mask_f();
    localparam pipeline_signal_t COP0_KEEP_MASK        = cop0_keep_mask_f();
    localparam pipeline_signal_t INSTR_FIELD_MASK      = instr_mask_f();
    localparam pipeline_signal_t CLEAR_PIPELINE_SIGNAL = get_clear_control();

endpackage

// File: rtl/pipeline_elastic_stage_ring.sv
// ---------------------------------------------------------------------------
// elastic_ring_buffer
// DEPTH-entry circular buffer: storage, read/write pointers, occupancy,
// flush and reset clear. Pointers wrap explicitly, so DEPTH need not be a
// power of two. The caller guarantees push only when not full and pop only
// when not empty.
// Ports:
//   clk, reset (async, active low)
//   push, wr_data : write wr_data at wr_ptr
//   pop           : retire the entry at rd_ptr
//   flush         : empty the buffer (beats push/pop)
//   rd_data       : entry at rd_ptr
//   count         : occupancy
// ---------------------------------------------------------------------------
module elastic_ring_buffer
    import pipeline_pkg::*;
#(
    parameter int               WIDTH       = PIPELINE_SIGNAL_W,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    logic [DEPTH-1:0][WIDTH-1:0] mem_rd;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;

    // One register per entry; each clears to CLEAR_VALUE on reset so that
    // no stale payload survives a reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= CLEAR_VALUE;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign mem_rd[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem_rd[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/pipeline_elastic_stage.sv
// ---------------------------------------------------------------------------
// pipeline_elastic_stage
// Elastic pipeline register: a DEPTH-entry buffer with valid/ready on both
// sides, preserving the stall / bubble / nullify semantics of the single
// register stage and adding flush and masked field retention on nullify.
// Ports:
//   clk, reset (async, active low)
//   in_valid / in_ready / in_data    : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and head payload
//   stall          : freeze, neither push nor pop
//   bubble         : block pushes, pops continue
//   nullify        : clear NULLIFY_MASK bits of this cycle's push
//   nullify_instr  : also zero INSTR_MASK bits of a nullified push
//   keep_exception : keep KEEP_MASK bits of in_data on a nullified push
//   flush          : discard all entries
//   count          : occupancy
// ---------------------------------------------------------------------------
module pipeline_elastic_stage
    import pipeline_pkg::*;
#(
    parameter int               WIDTH        = PIPELINE_SIGNAL_W,
    parameter int               DEPTH        = 2,
    parameter logic [WIDTH-1:0] CLEAR_VALUE  = '0,
    parameter logic [WIDTH-1:0] NULLIFY_MASK = '0,
    parameter logic [WIDTH-1:0] KEEP_MASK    = '0,
    parameter logic [WIDTH-1:0] INSTR_MASK   = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       stall,
    input  logic                       bubble,
    input  logic                       nullify,
    input  logic                       nullify_instr,
    input  logic                       keep_exception,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $fatal(1, "pipeline_elastic_stage: DEPTH must be >= 1");
        end
    endgenerate

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] head_data;
    logic [CNT_W-1:0] count_int;

    // in_ready deliberately ignores out_ready so the stage never forms a
    // combinational ready path through itself.
    assign in_ready  = reset && !stall && !bubble && !flush && (count_int < CNT_W'(DEPTH));
    assign out_valid = (count_int != '0) && !stall;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // An empty stage presents the clear image so downstream sees inert control.
    assign out_data  = (count_int != '0) ? head_data : CLEAR_VALUE;
    assign count     = count_int;

    // Nullify transform: control field returns to its clear value, the cop0
    // exception fields optionally survive, the instruction optionally zeroes.
    always_comb begin
        push_data = in_data;
        if (nullify) begin
            push_data = (in_data & ~NULLIFY_MASK) | (CLEAR_VALUE & NULLIFY_MASK);
            if (keep_exception) begin
                push_data = (push_data & ~KEEP_MASK) | (in_data & KEEP_MASK);
            end
            if (nullify_instr) begin
                push_data = push_data & ~INSTR_MASK;
            end
        end
    end

    elastic_ring_buffer #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .CLEAR_VALUE (CLEAR_VALUE)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .flush   (flush),
        .rd_data (head_data),
        .count   (count_int)
    );

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
module tb_pipeline_elastic_stage;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT0: DEPTH=2
    logic       in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 0;
    logic [7:0] in_data0 = 0, out_data0;
    logic       stall0 = 0, bubble0 = 0, nullify0 = 0, nullify_instr0 = 0;
    logic       keep_exception0 = 0, flush0 = 0;
    logic [1:0] count0;

    // DUT1: DEPTH=3
    logic       in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0;
    logic [7:0] in_data1 = 0, out_data1;
    logic [1:0] count1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         pop1_cnt = 0;
    logic [7:0] exp0, exp1;

    pipeline_elastic_stage #(
        .WIDTH(8), .DEPTH(2), .CLEAR_VALUE(8'hF0), .NULLIFY_MASK(8'hF0),
        .KEEP_MASK(8'h30), .INSTR_MASK(8'h0F)
    ) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .stall(stall0), .bubble(bubble0), .nullify(nullify0),
        .nullify_instr(nullify_instr0), .keep_exception(keep_exception0),
        .flush(flush0), .count(count0)
    );

    pipeline_elastic_stage #(
        .WIDTH(8), .DEPTH(3), .CLEAR_VALUE(8'hF0), .NULLIFY_MASK(8'hF0),
        .KEEP_MASK(8'h30), .INSTR_MASK(8'h0F)
    ) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .stall(1'b0), .bubble(1'b0), .nullify(1'b0),
        .nullify_instr(1'b0), .keep_exception(1'b0),
        .flush(1'b0), .count(count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] d, input logic [7:0] e);
        in_valid0 = 1'b1;
        in_data0  = d;
        q0.push_back(e);
    endtask

    // Scoreboard monitors: a pop happens on the coming edge, compare head now.
    always @(negedge clk) begin
        if (reset && out_valid0 && out_ready0 && !flush0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL pop0 unexpected got=%h want=none", out_data0);
            end else begin
                exp0 = q0.pop_front();
                chk("pop0", {24'd0, out_data0}, {24'd0, exp0});
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid1 && out_ready1) begin
            pop1_cnt++;
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL pop1 unexpected got=%h want=none", out_data1);
            end else begin
                exp1 = q1.pop_front();
                chk("pop1", {24'd0, out_data1}, {24'd0, exp1});
            end
        end
    end

    initial begin
        int nxt, m, c, max_cnt;
        logic push_e, pop_e;

        // ---- 1: reset behaviour ----
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data0}, 32'hF0);
        chk("rst_in_ready",  {31'd0, in_ready0}, 32'd0);
        chk("rst_count",     {30'd0, count0}, 32'd0);
        reset = 1'b1;
        step();
        push0(8'hA5, 8'hA5);
        step();
        push0(8'h3C, 8'h3C);
        step();
        in_valid0 = 1'b0;
        #1;
        chk("pre_rst_count", {30'd0, count0}, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("midrst_out_data",  {24'd0, out_data0}, 32'hF0);
        chk("midrst_count",     {30'd0, count0}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready0}, 32'd0);
        q0.delete();
        step();
        reset = 1'b1;
        step();
        chk("post_rst_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("post_rst_count",    {30'd0, count0}, 32'd0);

        // ---- 2: fill and drain in order ----
        push0(8'hA5, 8'hA5);
        step();
        push0(8'h3C, 8'h3C);
        step();
        in_valid0 = 1'b0;
        #1;
        chk("full_count",     {30'd0, count0}, 32'd2);
        chk("full_in_ready",  {31'd0, in_ready0}, 32'd0);
        chk("full_out_data",  {24'd0, out_data0}, 32'hA5);
        chk("full_out_valid", {31'd0, out_valid0}, 32'd1);
        out_ready0 = 1'b1;
        step();
        #1;
        chk("drain1_count", {30'd0, count0}, 32'd1);
        chk("drain1_head",  {24'd0, out_data0}, 32'h3C);
        step();
        out_ready0 = 1'b0;
        #1;
        chk("drain2_count",     {30'd0, count0}, 32'd0);
        chk("drain2_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("drain2_out_data",  {24'd0, out_data0}, 32'hF0);

        // ---- 3: nullify transform ----
        out_ready0 = 1'b1;
        nullify0 = 1'b1; keep_exception0 = 1'b0; nullify_instr0 = 1'b0;
        push0(8'hAB, 8'hFB);
        step();
        keep_exception0 = 1'b1;
        push0(8'hAB, 8'hEB);
        step();
        nullify_instr0 = 1'b1;
        push0(8'hAB, 8'hE0);
        step();
        nullify0 = 1'b0;
        push0(8'h5A, 8'h5A);
        step();
        in_valid0 = 1'b0; keep_exception0 = 1'b0; nullify_instr0 = 1'b0;
        step();
        step();
        chk("nullify_drain_count", {30'd0, count0}, 32'd0);

        // ---- 4: stall holds everything ----
        out_ready0 = 1'b0;
        push0(8'h77, 8'h77);
        step();
        in_data0 = 8'h99; stall0 = 1'b1; out_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready",  {31'd0, in_ready0}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid0}, 32'd0);
            chk("stall_count",     {30'd0, count0}, 32'd1);
            chk("stall_head",      {24'd0, out_data0}, 32'h77);
            step();
        end
        stall0 = 1'b0; in_valid0 = 1'b0;
        step();
        out_ready0 = 1'b0;
        #1;
        chk("unstall_count", {30'd0, count0}, 32'd0);

        // ---- 5a: bubble blocks pushes, pops continue ----
        push0(8'h11, 8'h11);
        step();
        push0(8'h22, 8'h22);
        step();
        in_data0 = 8'h33; bubble0 = 1'b1; out_ready0 = 1'b1;
        #1;
        chk("bubble_in_ready", {31'd0, in_ready0}, 32'd0);
        chk("bubble_count0",   {30'd0, count0}, 32'd2);
        step();
        #1;
        chk("bubble_count1", {30'd0, count0}, 32'd1);
        step();
        #1;
        chk("bubble_count2", {30'd0, count0}, 32'd0);
        bubble0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;

        // ---- 5b: flush discards entries and the concurrent input ----
        step();
        push0(8'h44, 8'h44);
        step();
        push0(8'h55, 8'h55);
        step();
        q0.delete();
        in_valid0 = 1'b1; in_data0 = 8'h66; flush0 = 1'b1; out_ready0 = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready0}, 32'd0);
        chk("flush_count0",   {30'd0, count0}, 32'd2);
        step();
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        #1;
        chk("flush_count1",     {30'd0, count0}, 32'd0);
        chk("flush_out_valid",  {31'd0, out_valid0}, 32'd0);
        chk("flush_out_data",   {24'd0, out_data0}, 32'hF0);
        push0(8'h12, 8'h12);
        step();
        in_valid0 = 1'b0;
        #1;
        chk("post_flush_count", {30'd0, count0}, 32'd1);
        chk("post_flush_head",  {24'd0, out_data0}, 32'h12);
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
        #1;
        chk("post_flush_drain", {30'd0, count0}, 32'd0);

        // ---- 6: DEPTH=3 streaming with wrap ----
        nxt = 1; m = 0; c = 0; max_cnt = 0;
        while ((nxt <= 7 || m > 0) && c < 60) begin
            step();
            in_valid1  = (nxt <= 7);
            in_data1   = 8'(nxt);
            out_ready1 = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            chk("s6_in_ready", {31'd0, in_ready1}, {31'd0, (m < 3)});
            chk("s6_count",    {30'd0, count1}, 32'(m));
            if (int'(count1) > max_cnt) max_cnt = int'(count1);
            push_e = in_valid1 && (m < 3);
            pop_e  = (m > 0) && out_ready1;
            if (push_e) begin
                q1.push_back(8'(nxt));
                nxt++;
            end
            m = m + (push_e ? 1 : 0) - (pop_e ? 1 : 0);
            c++;
        end
        step();
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        if (c >= 60) begin
            total++; bad++;
            $display("FAIL s6_timeout got=%0d want=<60", c);
        end
        step();
        #1;
        chk("s6_final_count", {30'd0, count1}, 32'd0);
        chk("s6_max_count",   32'(max_cnt), 32'd3);
        chk("s6_pops",        32'(pop1_cnt), 32'd7);
        chk("q0_left",        32'(q0.size()), 32'd0);
        chk("q1_left",        32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_elastic_stage.md
Name: pipeline_elastic_stage

Overview:
Parametrised successor to the single-register pipeline stage. It is a DEPTH-entry elastic buffer with a valid/ready handshake on both sides, so adjacent stages can decouple instead of freezing in lockstep. It keeps the existing stall, bubble and nullify semantics, and adds flush, a configurable clear value, and masked field retention on nullify. It sits between any two pipeline stages, carrying a packed pipeline_signal_t of WIDTH bits.

Parameters:
WIDTH, 128, payload width in bits.
DEPTH, 2, buffer entries; must be >= 1 (elaboration assertion).
CLEAR_VALUE, '0, WIDTH-bit value loaded on reset and shown on out_data when empty; the wrapper passes the packed signals::get_clear_control() image.
NULLIFY_MASK, '0, payload bits forced to CLEAR_VALUE on a nullified push (the control field).
KEEP_MASK, '0, subset of NULLIFY_MASK kept from in_data when keep_exception=1 (write_cop0, dest_cop0_rd/sel/data).
INSTR_MASK, '0, payload bits forced to 0 on a nullified push when nullify_instr=1 (instruction field).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage accepts a beat this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  head entry available
out_ready  input  1  downstream accepts the head
out_data  output  WIDTH  head payload
stall  input  1  freeze: no push, no pop
bubble  input  1  no push; pops still allowed
nullify  input  1  apply nullify transform to this cycle's push
nullify_instr  input  1  additionally clear INSTR_MASK bits on a nullified push
keep_exception  input  1  retain KEEP_MASK bits on a nullified push
flush  input  1  discard all entries
count  output  $clog2(DEPTH+1)  occupancy

Behaviour:
- Storage: circular buffer mem[DEPTH] with rd_ptr, wr_ptr and count. Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of 2.
- Reset (asynchronous on reset=0): count=0, pointers=0, every mem entry=CLEAR_VALUE. Consequently out_valid=0, out_data=CLEAR_VALUE and in_ready=0 while reset is held. Normal operation resumes on the first clk edge after release.
- in_ready = reset && !stall && !bubble && !flush && (count < DEPTH). It has no combinational dependence on out_ready.
- out_valid = (count != 0) && !stall.
- out_data = mem[rd_ptr] when count != 0, else CLEAR_VALUE.
- push = in_valid && in_ready.
- pop = out_valid && out_ready && !flush.
- Pushed value:
  - nullify=0: in_data.
  - nullify=1: v = (in_data & ~NULLIFY_MASK) | (CLEAR_VALUE & NULLIFY_MASK).
  - keep_exception=1: v = (v & ~KEEP_MASK) | (in_data & KEEP_MASK).
  - nullify_instr=1: v &= ~INSTR_MASK.
  - nullify_instr and keep_exception are ignored when nullify=0.
  - nullify with no push has no effect.
- Count update on the clock edge:
  - flush → count=0, rd_ptr=wr_ptr=0.
  - push only → +1.
  - pop only → -1.
  - push and pop together → unchanged.
- Priority: reset > flush > stall > bubble > push/pop.
- Latency: a push into an empty buffer is visible on out_data the next cycle.
- Throughput: one beat per cycle when DEPTH >= 2. DEPTH=1 sustains one beat every 2 cycles, because a full buffer deasserts in_ready.
- Full: in_ready=0, in_data is ignored, and no overwrite occurs.
- Empty: out_valid=0 and out_data shows CLEAR_VALUE, so the downstream sees cleared control.
- Stall with count > 0: all state, including out_data, is held.
- Flush and push in the same cycle: the input is not accepted (in_ready=0).
- Reset asserted mid-transfer: the entry is lost and there is no partial update.

Decomposition:
- pipeline_pkg holds:
  - the width function for pipeline_signal_t;
  - the mask constants CONTROL_MASK, COP0_KEEP_MASK and INSTR_FIELD_MASK, derived from signals struct field offsets;
  - the packed clear-value constant.
- Sub-module elastic_ring_buffer implements storage, pointers, count, flush and reset clear. The top level adds the handshake gating and the nullify transform.

Test Plan:
(Config for scenarios 1–5: WIDTH=8, DEPTH=2, CLEAR_VALUE=8'hF0, NULLIFY_MASK=8'hF0, KEEP_MASK=8'h30, INSTR_MASK=8'h0F.)
1. Push A5, 3C with count=2 and out_ready=0, then assert reset=0 between edges → out_valid drops to 0 and out_data reads F0 immediately, count=0. After release, in_ready=1 on the next cycle.
2. Push A5, 3C back-to-back with out_ready=0 → count=2, in_ready=0, out_data=A5. Raise out_ready → A5 then 3C pop in order, then count=0.
3. Nullified push of AB:
   - keep_exception=0 → stored FB.
   - keep_exception=1 → stored EB.
   - keep_exception=1 and nullify_instr=1 → stored E0.
4. With count=1, hold stall=1, in_valid=1, out_ready=1 for 3 cycles → in_ready=0, out_valid=0, count stays 1, head unchanged. Release stall → pop on the next edge.
5. With count=2, set bubble=1, in_valid=1, out_ready=1 → in_ready=0 and pops proceed, count goes 2→1→0.
   Then with count=2, set flush=1 and in_valid=1 → next cycle count=0, out_data=F0, and the input is not stored.
6. DEPTH=3: stream 0x01..0x07 with out_ready toggling 1,0,0,1,… → output order 01..07 with none lost or duplicated, pointers wrap past entry 2, and count never exceeds 3.
